// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side bundle between the PC sequencer, imem, predictor, retire redirect and dispatch.
interface fetch_queue_if #(
  parameter int OBQ_IDX_W = 4,
  parameter int CNT_W = 4
);
  logic enable;
  logic [31:0] imem_data;
  logic imem_valid;
  logic imem_is_branch;
  logic bp_next_pc_valid;
  logic [31:0] bp_next_pc;
  logic [OBQ_IDX_W-1:0] bp_next_pc_index;
  logic redirect_en;
  logic [31:0] redirect_pc;
  logic deq_ready;
  logic [31:0] fetch_pc;
  logic fetch_pc_valid;
  logic if_branch;
  logic deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic [31:0] deq_npc;
  logic deq_obq_valid;
  logic [OBQ_IDX_W-1:0] deq_obq_index;
  logic [CNT_W-1:0] count;
  modport master (
    output enable, imem_data, imem_valid, imem_is_branch, bp_next_pc_valid, bp_next_pc,
           bp_next_pc_index, redirect_en, redirect_pc, deq_ready,
    input  fetch_pc, fetch_pc_valid, if_branch, deq_valid, deq_pc, deq_inst, deq_npc,
           deq_obq_valid, deq_obq_index, count
  );
  modport slave (
    input  enable, imem_data, imem_valid, imem_is_branch, bp_next_pc_valid, bp_next_pc,
           bp_next_pc_index, redirect_en, redirect_pc, deq_ready,
    output fetch_pc, fetch_pc_valid, if_branch, deq_valid, deq_pc, deq_inst, deq_npc,
           deq_obq_valid, deq_obq_index, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC sequencer plus instruction FIFO carrying predicted next PC and OBQ index.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int OBQ_IDX_W = 4
) (
  input logic clock,
  input logic reset,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, PRED} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, pend_pc, pend_inst, npc;
  logic pend_br, start, enq, deq, pred_hit;
  logic [31:0] mem_pc [DEPTH];
  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_npc [DEPTH];
  logic mem_ov [DEPTH];
  logic [OBQ_IDX_W-1:0] mem_oi [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  always_comb begin
    pred_hit = pend_br & bus.bp_next_pc_valid;
    npc = pred_hit ? bus.bp_next_pc : pend_pc + 32'd4;
    start = (state == FETCH) && bus.enable && bus.imem_valid && (count < FULL);
    enq = (state == PRED) && bus.enable && !bus.redirect_en;
    deq = (count != '0) && bus.deq_ready && !bus.redirect_en;
    state_nxt = state;
    if (bus.redirect_en) state_nxt = FETCH;
    else if (state == IDLE) state_nxt = bus.enable ? FETCH : IDLE;
    else if (state == FETCH) state_nxt = start ? PRED : FETCH;
    else state_nxt = bus.enable ? FETCH : PRED;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      pend_pc <= '0;
      pend_inst <= '0;
      pend_br <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (bus.redirect_en) begin
        fetch_pc <= bus.redirect_pc;
        pend_pc <= '0;
        pend_inst <= '0;
        pend_br <= 1'b0;
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (start) begin
          pend_pc <= fetch_pc;
          pend_inst <= bus.imem_data;
          pend_br <= bus.imem_is_branch;
        end
        if (enq) begin
          fetch_pc <= npc;
          tail <= tail + 1'b1;
        end
        if (deq) head <= head + 1'b1;
        if (enq != deq) count <= enq ? count + 1'b1 : count - 1'b1;
      end
    end
  end
  // storage is reset too so the head fields read zero out of reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i] <= '0;
        mem_inst[i] <= '0;
        mem_npc[i] <= '0;
        mem_ov[i] <= 1'b0;
        mem_oi[i] <= '0;
      end
    end else if (enq) begin
      mem_pc[tail] <= pend_pc;
      mem_inst[tail] <= pend_inst;
      mem_npc[tail] <= npc;
      mem_ov[tail] <= pred_hit;
      mem_oi[tail] <= pred_hit ? bus.bp_next_pc_index : '0;
    end
  end
  assign bus.fetch_pc = fetch_pc;
  assign bus.fetch_pc_valid = (state == FETCH);
  assign bus.if_branch = bus.imem_valid & bus.imem_is_branch & (state == FETCH);
  assign bus.deq_valid = (count != '0);
  assign bus.deq_pc = mem_pc[head];
  assign bus.deq_inst = mem_inst[head];
  assign bus.deq_npc = mem_npc[head];
  assign bus.deq_obq_valid = mem_ov[head];
  assign bus.deq_obq_index = mem_oi[head];
  assign bus.count = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized stimulus scored against a queue-based model of the fetch stream.
module tb_fetch_queue;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  fetch_queue_if #(.OBQ_IDX_W(4), .CNT_W(4)) bus ();
  fetch_queue #(.DEPTH(8), .RESET_PC(32'h0), .OBQ_IDX_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic ov;
    logic [3:0] oi;
  } ent_t;
  ent_t q[$];
  ent_t pend;
  logic pend_br;
  logic [31:0] m_pc;
  int mode;  // 0 idle, 1 fetching, 2 awaiting prediction
  int n_assert = 0;
  int n_fail = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_pc = 32'h0;
    mode = 0;
    pend_br = 1'b0;
  endtask
  task automatic check_state();
    chk("fetch_pc", bus.fetch_pc, m_pc);
    chk("fetch_pc_valid", 32'(bus.fetch_pc_valid), 32'(mode == 1));
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("deq_valid", 32'(bus.deq_valid), 32'(q.size() != 0));
    chk("if_branch", 32'(bus.if_branch), 32'(bus.imem_valid && bus.imem_is_branch && mode == 1));
    if (q.size() != 0) begin
      chk("deq_pc", bus.deq_pc, q[0].pc);
      chk("deq_inst", bus.deq_inst, q[0].inst);
      chk("deq_npc", bus.deq_npc, q[0].npc);
      chk("deq_obq_valid", 32'(bus.deq_obq_valid), 32'(q[0].ov));
      chk("deq_obq_index", 32'(bus.deq_obq_index), 32'(q[0].oi));
    end
  endtask
  task automatic tick();
    bit full;
    bit hit;
    ent_t e;
    bus.imem_data = $urandom;
    if (bus.redirect_en) begin
      q.delete();
      m_pc = bus.redirect_pc;
      mode = 1;
    end else begin
      full = q.size() >= 8;
      if (q.size() != 0 && bus.deq_ready) void'(q.pop_front());
      if (mode == 0 && bus.enable) mode = 1;
      else if (mode == 1 && bus.enable && bus.imem_valid && !full) begin
        pend.pc = m_pc;
        pend.inst = bus.imem_data;
        pend_br = bus.imem_is_branch;
        mode = 2;
      end else if (mode == 2 && bus.enable) begin
        hit = pend_br && bus.bp_next_pc_valid;
        e.pc = pend.pc;
        e.inst = pend.inst;
        e.npc = hit ? bus.bp_next_pc : pend.pc + 32'd4;
        e.ov = hit;
        e.oi = hit ? bus.bp_next_pc_index : 4'd0;
        q.push_back(e);
        m_pc = e.npc;
        mode = 1;
      end
    end
    @(posedge clock);
    @(negedge clock);
    check_state();
  endtask
  task automatic redirect_to(logic [31:0] pc);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.redirect_en = 1'b0;
  endtask
  initial begin
    bus.enable = 1'b1;
    bus.imem_data = '0;
    bus.imem_valid = 1'b0;
    bus.imem_is_branch = 1'b0;
    bus.bp_next_pc_valid = 1'b0;
    bus.bp_next_pc = '0;
    bus.bp_next_pc_index = '0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.deq_ready = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clock);
      chk("rst_fetch_pc", bus.fetch_pc, 32'h0);
      chk("rst_fetch_pc_valid", 32'(bus.fetch_pc_valid), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
      chk("rst_deq_pc", bus.deq_pc, 32'h0);
      chk("rst_deq_npc", bus.deq_npc, 32'h0);
    end
    reset = 1'b1;
    check_state();
    bus.imem_valid = 1'b1;
    tick();
    chk("start_fetch_pc_valid", 32'(bus.fetch_pc_valid), 32'd1);
    // sequential fill until the FIFO is full
    repeat (24) tick();
    chk("fill_count", 32'(bus.count), 32'd8);
    chk("fill_fetch_pc", bus.fetch_pc, 32'h20);
    chk("fill_fetch_pc_valid", 32'(bus.fetch_pc_valid), 32'd1);
    chk("fill_head_pc", bus.deq_pc, 32'h0);
    chk("fill_head_npc", bus.deq_npc, 32'h4);
    bus.imem_valid = 1'b0;
    bus.deq_ready = 1'b1;
    repeat (10) tick();
    chk("drain_count", 32'(bus.count), 32'd0);
    // predicted branch at 0x10
    bus.deq_ready = 1'b0;
    redirect_to(32'h10);
    bus.imem_valid = 1'b1;
    bus.imem_is_branch = 1'b1;
    tick();
    bus.imem_valid = 1'b0;
    bus.bp_next_pc_valid = 1'b1;
    bus.bp_next_pc = 32'h40;
    bus.bp_next_pc_index = 4'd3;
    tick();
    chk("br_fetch_pc", bus.fetch_pc, 32'h40);
    chk("br_deq_pc", bus.deq_pc, 32'h10);
    chk("br_deq_npc", bus.deq_npc, 32'h40);
    chk("br_obq_valid", 32'(bus.deq_obq_valid), 32'd1);
    chk("br_obq_index", 32'(bus.deq_obq_index), 32'd3);
    // same branch without a valid prediction; dequeue during redirect is void
    bus.deq_ready = 1'b1;
    redirect_to(32'h10);
    bus.deq_ready = 1'b0;
    bus.imem_valid = 1'b1;
    tick();
    bus.imem_valid = 1'b0;
    bus.bp_next_pc_valid = 1'b0;
    tick();
    chk("nbr_fetch_pc", bus.fetch_pc, 32'h14);
    chk("nbr_deq_npc", bus.deq_npc, 32'h14);
    chk("nbr_obq_valid", 32'(bus.deq_obq_valid), 32'd0);
    chk("nbr_obq_index", 32'(bus.deq_obq_index), 32'd0);
    // redirect while an instruction is pending with three entries queued
    bus.imem_is_branch = 1'b0;
    redirect_to(32'h0);
    bus.imem_valid = 1'b1;
    for (int i = 0; i < 40 && !(q.size() == 3 && mode == 2); i++) tick();
    chk("redir_setup_count", 32'(bus.count), 32'd3);
    bus.redirect_pc = 32'h100;
    redirect_to(32'h100);
    chk("redir_count", 32'(bus.count), 32'd0);
    chk("redir_deq_valid", 32'(bus.deq_valid), 32'd0);
    chk("redir_fetch_pc", bus.fetch_pc, 32'h100);
    chk("redir_fetch_pc_valid", 32'(bus.fetch_pc_valid), 32'd1);
    bus.imem_valid = 1'b0;
    repeat (2) tick();
    chk("redir_no_enq", 32'(bus.count), 32'd0);
    // streaming across pointer wrap with dequeue toggling every cycle
    bus.imem_valid = 1'b1;
    for (int i = 0; i < 40 && q.size() < 6; i++) tick();
    chk("wrap_setup_count", 32'(bus.count), 32'd6);
    for (int i = 0; i < 60; i++) begin
      bus.deq_ready = ~bus.deq_ready;
      bus.imem_is_branch = 1'($urandom);
      bus.bp_next_pc_valid = 1'($urandom);
      bus.bp_next_pc = $urandom & 32'hFFFF_FFFC;
      bus.bp_next_pc_index = 4'($urandom);
      tick();
    end
    // fully randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.enable = ($urandom_range(7) != 0);
      bus.imem_valid = ($urandom_range(3) != 0);
      bus.imem_is_branch = 1'($urandom);
      bus.bp_next_pc_valid = 1'($urandom);
      bus.bp_next_pc = $urandom;
      bus.bp_next_pc_index = 4'($urandom);
      bus.deq_ready = ($urandom_range(2) == 0);
      bus.redirect_en = ($urandom_range(31) == 0);
      bus.redirect_pc = $urandom;
      tick();
    end
    // asynchronous reset between edges with five entries and a pending fetch
    bus.enable = 1'b1;
    bus.redirect_en = 1'b0;
    bus.imem_is_branch = 1'b0;
    bus.deq_ready = 1'b0;
    redirect_to(32'h200);
    bus.imem_valid = 1'b1;
    for (int i = 0; i < 40 && !(q.size() == 5 && mode == 2); i++) tick();
    chk("areset_setup_count", 32'(bus.count), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("areset_count", 32'(bus.count), 32'd0);
    chk("areset_deq_valid", 32'(bus.deq_valid), 32'd0);
    chk("areset_fetch_pc", bus.fetch_pc, 32'h0);
    chk("areset_fetch_pc_valid", 32'(bus.fetch_pc_valid), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    check_state();
    repeat (6) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
